// File: rtl/rob_if.sv
// -----------------------------------------------------------------------------
// rob_pkg / rob_if
// Purpose : micro-op bundle type and the dispatch / finish / commit bus of the
//           reorder buffer.
// Signals : flush              discard all ROB entries
//           dispatch_valid     dispatch offers a pair
//           dispatch_uop0/1    pair contents (.valid marks a live slot)
//           dispatch_ready     ROB can accept a pair
//           dispatch_robID     row index allocated to the offered pair
//           fin_valid[2:0]     per-port completion strobe (ALU0, ALU1, LSU/MDU)
//           fin_id[2:0]        completed op id {row, slot}
//           commit_valid       head row complete and offered to commit
//           commit_uop0/1      head row contents
//           commit_slot_valid  per-slot live bits of head row
//           commit_ready       commit stage accepts head row
// Modports: master = pipeline side, slave = ROB side.
// -----------------------------------------------------------------------------
package rob_pkg;
    typedef struct packed {
        logic        valid;
        logic [7:0]  opcode;
        logic [4:0]  rd;
        logic [31:0] pc;
    } UOPBundle;
endpackage

interface rob_if #(
    parameter int ROW_W = 4
);
    import rob_pkg::*;

    logic                   flush;
    logic                   dispatch_valid;
    UOPBundle               dispatch_uop0;
    UOPBundle               dispatch_uop1;
    logic                   dispatch_ready;
    logic [ROW_W-1:0]       dispatch_robID;
    logic [2:0]             fin_valid;
    logic [2:0][ROW_W:0]    fin_id;
    logic                   commit_valid;
    UOPBundle               commit_uop0;
    UOPBundle               commit_uop1;
    logic [1:0]             commit_slot_valid;
    logic                   commit_ready;

    modport master (
        output flush, dispatch_valid, dispatch_uop0, dispatch_uop1,
               fin_valid, fin_id, commit_ready,
        input  dispatch_ready, dispatch_robID,
               commit_valid, commit_uop0, commit_uop1, commit_slot_valid
    );

    modport slave (
        input  flush, dispatch_valid, dispatch_uop0, dispatch_uop1,
               fin_valid, fin_id, commit_ready,
        output dispatch_ready, dispatch_robID,
               commit_valid, commit_uop0, commit_uop1, commit_slot_valid
    );
endinterface

// File: rtl/rob.sv
// -----------------------------------------------------------------------------
// rob
// Purpose : in-order reorder buffer holding dispatch pairs (one pair per row).
//           Rows are allocated at the tail, marked finished per slot by three
//           completion ports, and retired from the head once both slots of the
//           head row are finished.
// Ports   : clk  sole clock (rising edge)
//           rst  synchronous active-high reset
//           bus  rob_if.slave: dispatch, finish and commit handshakes
// -----------------------------------------------------------------------------
module rob
    import rob_pkg::*;
#(
    parameter int ROB_ROWS = 16,
    parameter int ROW_W    = $clog2(ROB_ROWS)
) (
    input  logic  clk,
    input  logic  rst,
    rob_if.slave  bus
);
    localparam logic [ROW_W:0] FULL = (ROW_W+1)'(ROB_ROWS);

    UOPBundle              uop0_q [ROB_ROWS];
    UOPBundle              uop1_q [ROB_ROWS];
    logic [ROB_ROWS-1:0]   busy_q, busy_d;
    logic [ROB_ROWS-1:0]   fin0_q, fin0_d;
    logic [ROB_ROWS-1:0]   fin1_q, fin1_d;
    logic [ROW_W-1:0]      head_q, head_d;
    logic [ROW_W-1:0]      tail_q, tail_d;
    logic [ROW_W:0]        count_q, count_d;

    logic                  disp_fire;
    logic                  commit_fire;
    logic                  head_done;
    logic [ROW_W-1:0]      fin_row;

    // Ready and commit_valid come from registered state only.
    assign disp_fire   = bus.dispatch_valid && (count_q != FULL);
    assign head_done   = busy_q[head_q] && fin0_q[head_q] && fin1_q[head_q];
    assign commit_fire = head_done && bus.commit_ready;

    assign bus.dispatch_ready    = (count_q != FULL);
    assign bus.dispatch_robID    = tail_q;
    assign bus.commit_valid      = head_done;
    assign bus.commit_uop0       = uop0_q[head_q];
    assign bus.commit_uop1       = uop1_q[head_q];
    // Gated so the un-reset payload storage never leaks out while idle.
    assign bus.commit_slot_valid = head_done ? {uop1_q[head_q].valid, uop0_q[head_q].valid} : '0;

    always_comb begin
        busy_d  = busy_q;
        fin0_d  = fin0_q;
        fin1_d  = fin1_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        fin_row = '0;

        // Finishes first so a same-cycle dispatch initialisation overrides them.
        for (int unsigned p = 0; p < 3; p++) begin
            fin_row = bus.fin_id[p][ROW_W:1];
            if (bus.fin_valid[p] && busy_q[fin_row]) begin
                if (bus.fin_id[p][0]) fin1_d[fin_row] = 1'b1;
                else                  fin0_d[fin_row] = 1'b1;
            end
        end

        if (commit_fire) begin
            busy_d[head_q] = 1'b0;
            head_d         = head_q + 1'b1;
        end

        // Dead slots are pre-finished so a pair commits on its live slots only.
        if (disp_fire) begin
            busy_d[tail_q] = 1'b1;
            fin0_d[tail_q] = ~bus.dispatch_uop0.valid;
            fin1_d[tail_q] = ~bus.dispatch_uop1.valid;
            tail_d         = tail_q + 1'b1;
        end

        unique case ({disp_fire, commit_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            busy_q  <= '0;
            fin0_q  <= '0;
            fin1_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            fin0_q  <= fin0_d;
            fin1_q  <= fin1_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset: it is only observed through busy rows.
    always_ff @(posedge clk) begin
        if (disp_fire) begin
            uop0_q[tail_q] <= bus.dispatch_uop0;
            uop1_q[tail_q] <= bus.dispatch_uop1;
        end
    end
endmodule

// File: tb/tb_rob.sv
// -----------------------------------------------------------------------------
// tb_rob
// Purpose : self-checking bench for rob. Directed scenario tasks check the
//           handshake outputs inline; a negedge scoreboard queues each accepted
//           pair and compares it against the commit port when the row retires.
// -----------------------------------------------------------------------------
module tb_rob;
    import rob_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rob_if #(.ROW_W(4)) bus ();

    rob #(.ROB_ROWS(16), .ROW_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        UOPBundle   u0;
        UOPBundle   u1;
        logic [1:0] sv;
    } exp_t;

    exp_t       sb[$];
    int         total  = 0;
    int         bad    = 0;
    int         mcount = 0;
    logic [3:0] mtail  = '0;
    int         tagc   = 0;

    // ---------------------------------------------------------------- scoreboard
    always @(negedge clk) begin : monitor
        exp_t e;
        logic fd;
        logic fc;
        logic want_rdy;
        if (rst || bus.flush) begin
            sb.delete();
            mcount = 0;
            mtail  = '0;
        end else begin
            want_rdy = (mcount != 16);
            fd = bus.dispatch_valid && want_rdy;
            total++;
            if (bus.dispatch_ready !== want_rdy) begin
                bad++;
                $display("FAIL sb_ready: got %b want %b", bus.dispatch_ready, want_rdy);
            end
            if (fd) begin
                total++;
                if (bus.dispatch_robID !== mtail) begin
                    bad++;
                    $display("FAIL sb_robid: got %0d want %0d", bus.dispatch_robID, mtail);
                end
                e.u0 = bus.dispatch_uop0;
                e.u1 = bus.dispatch_uop1;
                e.sv = {bus.dispatch_uop1.valid, bus.dispatch_uop0.valid};
                sb.push_back(e);
            end
            fc = bus.commit_valid && bus.commit_ready;
            if (fc) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_commit: got unexpected commit want none");
                end else begin
                    e = sb.pop_front();
                    if ({bus.commit_uop0, bus.commit_uop1, bus.commit_slot_valid} !== {e.u0, e.u1, e.sv}) begin
                        bad++;
                        $display("FAIL sb_commit: got %h/%h/%b want %h/%h/%b",
                                 bus.commit_uop0, bus.commit_uop1, bus.commit_slot_valid, e.u0, e.u1, e.sv);
                    end
                end
            end
            mcount = mcount + int'(fd) - int'(fc);
            if (fd) mtail = mtail + 1'b1;
        end
    end

    // ------------------------------------------------------------------ helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush          = 1'b0;
        bus.dispatch_valid = 1'b0;
        bus.fin_valid      = '0;
        bus.fin_id         = '0;
        bus.commit_ready   = 1'b0;
    endtask

    task automatic mk(input logic v, output UOPBundle u);
        tagc++;
        u.valid  = v;
        u.opcode = 8'(tagc);
        u.rd     = 5'(tagc * 3);
        u.pc     = $urandom;
    endtask

    task automatic offer(input logic v0, input logic v1);
        UOPBundle a, b;
        mk(v0, a);
        mk(v1, b);
        bus.dispatch_valid = 1'b1;
        bus.dispatch_uop0  = a;
        bus.dispatch_uop1  = b;
    endtask

    task automatic fin3(input logic [2:0] v, input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        bus.fin_valid = v;
        bus.fin_id[0] = a;
        bus.fin_id[1] = b;
        bus.fin_id[2] = c;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // -------------------------------------------------------------------- tests
    task automatic test_reset();
        idle();
        offer(1'b1, 1'b1);
        fin3(3'b111, 5'd0, 5'd1, 5'd2);
        bus.commit_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        total++; if (bus.dispatch_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.dispatch_ready); end
        total++; if (bus.dispatch_robID !== 4'd0) begin bad++; $display("FAIL reset_robid: got %0d want 0", bus.dispatch_robID); end
        total++; if (bus.commit_valid !== 1'b0) begin bad++; $display("FAIL reset_cv: got %b want 0", bus.commit_valid); end
        total++; if (bus.commit_slot_valid !== 2'b00) begin bad++; $display("FAIL reset_sv: got %b want 00", bus.commit_slot_valid); end
        rst = 1'b0;
        idle();
    endtask

    task automatic test_single();
        offer(1'b1, 1'b0);
        total++; if (bus.dispatch_robID !== 4'd0) begin bad++; $display("FAIL single_robid0: got %0d want 0", bus.dispatch_robID); end
        tick();
        idle();
        total++; if (bus.dispatch_robID !== 4'd1) begin bad++; $display("FAIL single_robid1: got %0d want 1", bus.dispatch_robID); end
        total++; if (bus.commit_valid !== 1'b0) begin bad++; $display("FAIL single_cv_early: got %b want 0", bus.commit_valid); end
        fin3(3'b001, 5'b00000, 5'd0, 5'd0);
        tick();
        idle();
        total++; if (bus.commit_valid !== 1'b1) begin bad++; $display("FAIL single_cv: got %b want 1", bus.commit_valid); end
        total++; if (bus.commit_slot_valid !== 2'b01) begin bad++; $display("FAIL single_sv: got %b want 01", bus.commit_slot_valid); end
        bus.commit_ready = 1'b1;
        tick();
        idle();
        total++; if (bus.commit_valid !== 1'b0) begin bad++; $display("FAIL single_cv_after: got %b want 0", bus.commit_valid); end
    endtask

    task automatic test_full();
        pulse_rst();
        for (int i = 0; i < 16; i++) begin
            offer(1'b1, 1'b1);
            total++; if (bus.dispatch_robID !== 4'(i)) begin bad++; $display("FAIL full_robid: got %0d want %0d", bus.dispatch_robID, i); end
            tick();
        end
        total++; if (bus.dispatch_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b want 0", bus.dispatch_ready); end
        total++; if (bus.dispatch_robID !== 4'd0) begin bad++; $display("FAIL full_wrap: got %0d want 0", bus.dispatch_robID); end
        offer(1'b1, 1'b1);
        tick();
        total++; if (bus.dispatch_ready !== 1'b0) begin bad++; $display("FAIL full_17th_ready: got %b want 0", bus.dispatch_ready); end
        total++; if (bus.dispatch_robID !== 4'd0) begin bad++; $display("FAIL full_17th_robid: got %0d want 0", bus.dispatch_robID); end
        idle();
    endtask

    task automatic test_full_commit();
        fin3(3'b011, 5'd0, 5'd1, 5'd0);
        tick();
        idle();
        total++; if (bus.commit_valid !== 1'b1) begin bad++; $display("FAIL fc_cv: got %b want 1", bus.commit_valid); end
        offer(1'b1, 1'b0);
        bus.commit_ready = 1'b1;
        tick();
        bus.commit_ready = 1'b0;
        total++; if (bus.dispatch_ready !== 1'b1) begin bad++; $display("FAIL fc_ready: got %b want 1", bus.dispatch_ready); end
        total++; if (bus.dispatch_robID !== 4'd0) begin bad++; $display("FAIL fc_robid: got %0d want 0", bus.dispatch_robID); end
        total++; if (bus.commit_valid !== 1'b0) begin bad++; $display("FAIL fc_cv_row1: got %b want 0", bus.commit_valid); end
        tick();
        idle();
        total++; if (bus.dispatch_ready !== 1'b0) begin bad++; $display("FAIL fc_refull: got %b want 0", bus.dispatch_ready); end
        total++; if (bus.dispatch_robID !== 4'd1) begin bad++; $display("FAIL fc_robid1: got %0d want 1", bus.dispatch_robID); end
    endtask

    task automatic test_inorder();
        rst = 1'b1;
        offer(1'b1, 1'b1);
        tick();
        rst = 1'b0;
        idle();
        total++; if (bus.dispatch_robID !== 4'd0) begin bad++; $display("FAIL io_rst_disp: got %0d want 0", bus.dispatch_robID); end
        offer(1'b1, 1'b1);
        tick();
        offer(1'b1, 1'b1);
        tick();
        idle();
        bus.commit_ready = 1'b1;
        fin3(3'b111, 5'd2, 5'd3, 5'd1);
        tick();
        bus.fin_valid = '0;
        total++; if (bus.commit_valid !== 1'b0) begin bad++; $display("FAIL io_wait0: got %b want 0", bus.commit_valid); end
        tick();
        total++; if (bus.commit_valid !== 1'b0) begin bad++; $display("FAIL io_wait1: got %b want 0", bus.commit_valid); end
        fin3(3'b001, 5'd0, 5'd0, 5'd0);
        tick();
        bus.fin_valid = '0;
        total++; if (bus.commit_valid !== 1'b1) begin bad++; $display("FAIL io_row0: got %b want 1", bus.commit_valid); end
        total++; if (bus.commit_slot_valid !== 2'b11) begin bad++; $display("FAIL io_row0_sv: got %b want 11", bus.commit_slot_valid); end
        tick();
        total++; if (bus.commit_valid !== 1'b1) begin bad++; $display("FAIL io_row1: got %b want 1", bus.commit_valid); end
        tick();
        total++; if (bus.commit_valid !== 1'b0) begin bad++; $display("FAIL io_empty: got %b want 0", bus.commit_valid); end
        total++; if (bus.dispatch_robID !== 4'd2) begin bad++; $display("FAIL io_robid: got %0d want 2", bus.dispatch_robID); end
        idle();
    endtask

    task automatic test_multi_finish();
        pulse_rst();
        offer(1'b1, 1'b1);
        tick();
        offer(1'b1, 1'b1);
        tick();
        idle();
        fin3(3'b011, 5'd0, 5'd1, 5'd0);
        tick();
        fin3(3'b111, 5'b00010, 5'b00011, 5'b00011);
        tick();
        idle();
        total++; if (bus.commit_valid !== 1'b1) begin bad++; $display("FAIL mf_row0: got %b want 1", bus.commit_valid); end
        bus.commit_ready = 1'b1;
        tick();
        total++; if (bus.commit_valid !== 1'b1) begin bad++; $display("FAIL mf_row1: got %b want 1", bus.commit_valid); end
        tick();
        total++; if (bus.commit_valid !== 1'b0) begin bad++; $display("FAIL mf_empty: got %b want 0", bus.commit_valid); end
        idle();
    endtask

    task automatic test_flush();
        pulse_rst();
        for (int i = 0; i < 5; i++) begin
            offer(1'b1, 1'b1);
            tick();
        end
        idle();
        total++; if (bus.dispatch_robID !== 4'd5) begin bad++; $display("FAIL fl_robid5: got %0d want 5", bus.dispatch_robID); end
        fin3(3'b011, 5'd0, 5'd1, 5'd0);
        tick();
        idle();
        total++; if (bus.commit_valid !== 1'b1) begin bad++; $display("FAIL fl_cv_pre: got %b want 1", bus.commit_valid); end
        bus.flush = 1'b1;
        offer(1'b1, 1'b1);
        bus.commit_ready = 1'b1;
        fin3(3'b001, 5'd2, 5'd0, 5'd0);
        tick();
        idle();
        total++; if (bus.dispatch_robID !== 4'd0) begin bad++; $display("FAIL fl_robid: got %0d want 0", bus.dispatch_robID); end
        total++; if (bus.dispatch_ready !== 1'b1) begin bad++; $display("FAIL fl_ready: got %b want 1", bus.dispatch_ready); end
        total++; if (bus.commit_valid !== 1'b0) begin bad++; $display("FAIL fl_cv: got %b want 0", bus.commit_valid); end
        fin3(3'b011, 5'd0, 5'd1, 5'd0);
        tick();
        idle();
        total++; if (bus.commit_valid !== 1'b0) begin bad++; $display("FAIL fl_discard: got %b want 0", bus.commit_valid); end
        // reset in the middle of activity
        offer(1'b1, 1'b1);
        tick();
        offer(1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        total++; if (bus.dispatch_robID !== 4'd0) begin bad++; $display("FAIL mid_rst_robid: got %0d want 0", bus.dispatch_robID); end
        total++; if (bus.commit_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_cv: got %b want 0", bus.commit_valid); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] pending[$];
        logic v0, v1;
        int idx;
        pulse_rst();
        for (int cyc = 0; cyc < 200; cyc++) begin
            idle();
            if (cyc < 120 && $urandom_range(0, 3) != 0) begin
                v0 = 1'($urandom_range(0, 1));
                v1 = 1'($urandom_range(0, 1));
                offer(v0, v1);
            end
            bus.commit_ready = (cyc >= 120) || ($urandom_range(0, 3) != 0);
            for (int p = 0; p < 3; p++) begin
                if (pending.size() != 0 && $urandom_range(0, 1) == 1) begin
                    idx = $urandom_range(0, pending.size() - 1);
                    bus.fin_id[p]    = pending[idx];
                    bus.fin_valid[p] = 1'b1;
                    pending.delete(idx);
                end
            end
            if (bus.dispatch_valid && bus.dispatch_ready) begin
                if (bus.dispatch_uop0.valid) pending.push_back({bus.dispatch_robID, 1'b0});
                if (bus.dispatch_uop1.valid) pending.push_back({bus.dispatch_robID, 1'b1});
            end
            tick();
        end
        idle();
        total++; if (sb.size() != 0) begin bad++; $display("FAIL b2b_drain: got %0d rows left want 0", sb.size()); end
        total++; if (bus.commit_valid !== 1'b0) begin bad++; $display("FAIL b2b_cv_end: got %b want 0", bus.commit_valid); end
    endtask

    initial begin
        idle();
        test_reset();
        test_single();
        test_full();
        test_full_commit();
        test_inorder();
        test_multi_finish();
        test_flush();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rob.md
ROB -- requirements
Module: rob

Interface
REQ-001 Parameter ROB_ROWS, default 16, meaning number of ROB rows; each row holds one dispatch pair (slot 0, slot 1); power of two.
REQ-002 Parameter ROW_W, default $clog2(ROB_ROWS)=4, meaning row-index width; full ROB id width is ROW_W+1 as {row, slot}.
REQ-003 clk  input  1  sole clock, all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  discard all entries.
REQ-006 dispatch_valid  input  1  dispatch offers a pair this cycle.
REQ-007 dispatch_uop0 / dispatch_uop1  input  UOPBundle  pair contents; .valid marks a live slot.
REQ-008 dispatch_ready  output  1  ROB can accept a pair.
REQ-009 dispatch_robID  output  ROW_W  row index allocated to the offered pair (current tail).
REQ-010 fin_valid[2:0]  input  3  per-port completion strobe (ALU0, ALU1, LSU/MDU).
REQ-011 fin_id[2:0]  input  3 x (ROW_W+1)  completed op id {row, slot}.
REQ-012 commit_valid  output  1  head row complete and offered to commit.
REQ-013 commit_uop0 / commit_uop1  output  UOPBundle  head row contents.
REQ-014 commit_slot_valid  output  2  per-slot live bits of head row.
REQ-015 commit_ready  input  1  commit stage accepts head row.

Function
REQ-016 Storage: per row uop0, uop1, row_busy, fin[1:0]; head, tail pointers (ROW_W bits, wrap modulo ROB_ROWS); count (ROW_W+1 bits, 0..ROB_ROWS).
REQ-017 dispatch_ready = (count != ROB_ROWS), from registered count only; no combinational path from commit_ready.
REQ-018 dispatch_robID = tail; dispatch computes slot ids {tail,0}, {tail,1}.
REQ-019 Dispatch fire = dispatch_valid && dispatch_ready: next edge writes row[tail], row_busy=1, fin[s] = ~uop_s.valid (dead slots pre-finished), tail = tail+1.
REQ-020 dispatch_valid while full: no write, no pointer change; dispatch holds the pair.
REQ-021 Pair with both slots invalid is still allocated, pre-finished, and committed with commit_slot_valid=2'b00.
REQ-022 Finish: each fin_valid[p] sets fin[fin_id[p][0]] of row fin_id[p][ROW_W:1] on next edge; multiple ports may hit the same row/slot in one cycle; finish to a non-busy row is ignored.
REQ-023 Same-cycle dispatch write and finish to the same row: dispatch initialisation wins.
REQ-024 commit_valid = row_busy[head] && fin[head]==2'b11, registered state only; minimum finish-to-commit_valid latency 1 cycle.
REQ-025 commit_uop0/1, commit_slot_valid reflect row[head] whenever commit_valid=1; don't-care otherwise.
REQ-026 Commit fire = commit_valid && commit_ready: next edge clears row_busy[head], head = head+1.
REQ-027 count: +1 on dispatch fire only, -1 on commit fire only, unchanged on both or neither.
REQ-028 In-order: only head row may commit; younger complete rows wait.
REQ-029 flush: next edge head=tail=count=0, all row_busy and fin cleared; overrides same-cycle dispatch, finish and commit.

Reset
REQ-030 rst high at a rising edge: head=0, tail=0, count=0, all row_busy=0, fin=0; outputs dispatch_ready=1, dispatch_robID=0, commit_valid=0, commit_slot_valid=0.
REQ-031 rst overrides flush, dispatch, finish and commit in the same cycle; reset mid-operation discards all entries.

Verification
REQ-032 Reset, then dispatch pair (uop0.valid=1, uop1.valid=0) -> dispatch_robID=0 that cycle, count=1 next; finish id 5'b00000 -> commit_valid=1 one cycle later, commit_slot_valid=2'b01.
REQ-033 16 back-to-back dispatches, no finishes -> dispatch_ready=0 after 16th, 17th offer ignored, tail wrapped to 0.
REQ-034 Full ROB, finish both slots of row 0, commit_ready=1 and dispatch_valid=1 same cycle -> commit fires, dispatch stalls that cycle, dispatch_ready=1 next cycle, robID=0 reused.
REQ-035 Rows 0,1 dispatched; finish row 1 fully, row 0 slot 1 only -> commit_valid stays 0; finish row 0 slot 0 -> commit row 0 then row 1 in consecutive cycles.
REQ-036 Three ports finish ids 5'b00010, 5'b00011, 5'b00011 same cycle -> row 1 fin=2'b11 next cycle.
REQ-037 flush with count=5 and concurrent dispatch -> next cycle count=0, dispatch_robID=0, commit_valid=0, dispatched pair discarded.
